// File: rtl/motor_ramp_ctrl_if.sv
// Command channel into motor_ramp_ctrl: target duty and direction over a valid/ready handshake.
interface motor_ramp_ctrl_if #(
  parameter int PWM_WIDTH = 9
) ();
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_dir;
  logic [PWM_WIDTH-1:0] cmd_duty;

  modport master (output cmd_valid, output cmd_dir, output cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/motor_ramp_ctrl.sv
// H-bridge duty/direction sequencer: linear duty ramps, stop + dead time on reversal.
// Define MOTOR_RAMP_BRAKE_EN to drive in1=in2=1 (active brake) during dead time instead of coasting.
module motor_ramp_ctrl #(
  parameter int PWM_WIDTH  = 9,
  parameter int MAX_DUTY   = 320,
  parameter int RAMP_STEP  = 4,
  parameter int RAMP_TICKS = 6000,
  parameter int DEAD_TICKS = 60000
) (
  input  logic                 clk,
  input  logic                 rst,
  motor_ramp_ctrl_if.slave     cmd,
  output logic [PWM_WIDTH-1:0] duty,
  output logic                 pwm_ena,
  output logic                 in1,
  output logic                 in2,
  output logic                 at_target
);

  localparam int CNT_MAX = (RAMP_TICKS > DEAD_TICKS) ? RAMP_TICKS : DEAD_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [PWM_WIDTH-1:0] MAX_D     = PWM_WIDTH'(MAX_DUTY);
  localparam logic [PWM_WIDTH-1:0] STEP      = PWM_WIDTH'(RAMP_STEP);
  localparam logic [CW-1:0]        RAMP_LAST = CW'(RAMP_TICKS - 1);
  localparam logic [CW-1:0]        DEAD_LAST = CW'(DEAD_TICKS - 1);

`ifdef MOTOR_RAMP_BRAKE_EN
  localparam logic DEAD_LEVEL = 1'b1;
`else
  localparam logic DEAD_LEVEL = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RAMP, HOLD, STOP, DEAD} state_t;

  state_t               state, n_state;
  logic [PWM_WIDTH-1:0] target, n_target, n_duty, nd, req_duty;
  logic                 dir, n_dir, pending_dir, n_pending;
  logic [CW-1:0]        cnt, n_cnt, cnt_ramp;
  logic                 accept, ramp_wrap;

  // Differences are checked before any add/subtract so the step never overshoots or wraps.
  function automatic logic [PWM_WIDTH-1:0] step_toward(input logic [PWM_WIDTH-1:0] cur,
                                                       input logic [PWM_WIDTH-1:0] goal);
    logic [PWM_WIDTH-1:0] res;
    res = goal;
    if (cur < goal) begin
      if ((goal - cur) >= STEP) res = cur + STEP;
    end else if (cur > goal) begin
      if ((cur - goal) >= STEP) res = cur - STEP;
    end
    return res;
  endfunction

  assign accept    = cmd.cmd_valid && cmd.cmd_ready;
  assign req_duty  = (cmd.cmd_duty > MAX_D) ? MAX_D : cmd.cmd_duty;
  assign ramp_wrap = (cnt == RAMP_LAST);
  assign cnt_ramp  = ramp_wrap ? '0 : cnt + CW'(1);

  always_comb begin
    n_state   = state;
    n_duty    = duty;
    n_target  = target;
    n_dir     = dir;
    n_pending = pending_dir;
    n_cnt     = cnt;
    nd        = duty;
    case (state)
      IDLE: begin
        if (accept) begin
          n_target = req_duty;
          if (req_duty != '0) begin
            n_dir   = cmd.cmd_dir;
            n_state = RAMP;
            n_cnt   = '0;
          end
        end
      end
      RAMP, HOLD: begin
        if (accept) begin
          n_target = req_duty;
          if (cmd.cmd_dir != dir && duty != '0) begin
            n_pending = cmd.cmd_dir;
            n_state   = STOP;
          end else begin
            n_dir = cmd.cmd_dir;
            if (state == HOLD && req_duty != duty) n_state = RAMP;
          end
        end
        // Only a ramping state advances the tick counter; HOLD freezes it.
        if (state == RAMP) begin
          n_cnt  = cnt_ramp;
          nd     = ramp_wrap ? step_toward(duty, (n_state == STOP) ? '0 : n_target) : duty;
          n_duty = nd;
          if (n_state == RAMP && nd == n_target) begin
            n_state = (n_target == '0) ? IDLE : HOLD;
          end else if (n_state == STOP && nd == '0) begin
            n_state = DEAD;
            n_cnt   = '0;
          end
        end
      end
      STOP: begin
        n_cnt  = cnt_ramp;
        nd     = ramp_wrap ? step_toward(duty, '0) : duty;
        n_duty = nd;
        if (nd == '0) begin
          n_state = DEAD;
          n_cnt   = '0;
        end
      end
      DEAD: begin
        if (cnt == DEAD_LAST) begin
          n_dir   = pending_dir;
          n_cnt   = '0;
          n_state = (target != '0) ? RAMP : IDLE;
        end else begin
          n_cnt = cnt + CW'(1);
        end
      end
      default: n_state = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state/duty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      duty          <= '0;
      target        <= '0;
      dir           <= 1'b0;
      pending_dir   <= 1'b0;
      cnt           <= '0;
      in1           <= 1'b0;
      in2           <= 1'b0;
      pwm_ena       <= 1'b0;
      cmd.cmd_ready <= 1'b1;
      at_target     <= 1'b1;
    end else begin
      state         <= n_state;
      duty          <= n_duty;
      target        <= n_target;
      dir           <= n_dir;
      pending_dir   <= n_pending;
      cnt           <= n_cnt;
      cmd.cmd_ready <= (n_state == IDLE) || (n_state == RAMP) || (n_state == HOLD);
      pwm_ena       <= (n_state == RAMP) || (n_state == HOLD) || (n_state == STOP);
      at_target     <= (n_duty == n_target) && ((n_state == IDLE) || (n_state == HOLD));
      case (n_state)
        IDLE: begin
          in1 <= 1'b0;
          in2 <= 1'b0;
        end
        DEAD: begin
          in1 <= DEAD_LEVEL;
          in2 <= DEAD_LEVEL;
        end
        default: begin
          in1 <= ~n_dir;
          in2 <= n_dir;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Self-checking bench for motor_ramp_ctrl: per-cycle behavioural model plus hand-computed checkpoints.
module tb_motor_ramp_ctrl;

  localparam int W    = 9;
  localparam int MAXD = 320;
  localparam int STEP = 10;
  localparam int RT   = 4;
  localparam int DT   = 8;

`ifdef MOTOR_RAMP_BRAKE_EN
  localparam int BRAKE = 1;
`else
  localparam int BRAKE = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] duty;
  logic         pwm_ena, in1, in2, at_target;

  int checks   = 0;
  int errors   = 0;
  bit cmp_en   = 1'b0;
  int seen_max = 0;

  motor_ramp_ctrl_if #(.PWM_WIDTH(W)) cmd_bus ();

  motor_ramp_ctrl #(
    .PWM_WIDTH (W),
    .MAX_DUTY  (MAXD),
    .RAMP_STEP (STEP),
    .RAMP_TICKS(RT),
    .DEAD_TICKS(DT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_bus.slave),
    .duty     (duty),
    .pwm_ena  (pwm_ena),
    .in1      (in1),
    .in2      (in2),
    .at_target(at_target)
  );

  always #5 clk = ~clk;

  // Behavioural model: motor phase, duty and target as plain integers.
  typedef enum {COAST, DRIVE, CRUISE, BRAKING, DEADBAND} phase_t;
  phase_t m_ph     = COAST;
  int     m_duty   = 0;
  int     m_target = 0;
  int     m_timer  = 0;
  bit     m_dir    = 1'b0;
  bit     m_pend   = 1'b0;

  function automatic int move(input int cur, input int goal);
    int diff;
    diff = goal - cur;
    if (diff > STEP) return cur + STEP;
    if (diff < -STEP) return cur - STEP;
    return goal;
  endfunction

  function automatic int exp_ready();
    return (m_ph == COAST || m_ph == DRIVE || m_ph == CRUISE) ? 1 : 0;
  endfunction

  function automatic int exp_ena();
    return (m_ph == DRIVE || m_ph == CRUISE || m_ph == BRAKING) ? 1 : 0;
  endfunction

  function automatic int exp_in1();
    if (m_ph == COAST) return 0;
    if (m_ph == DEADBAND) return BRAKE;
    return m_dir ? 0 : 1;
  endfunction

  function automatic int exp_in2();
    if (m_ph == COAST) return 0;
    if (m_ph == DEADBAND) return BRAKE;
    return m_dir ? 1 : 0;
  endfunction

  function automatic int exp_at_target();
    return (m_duty == m_target && (m_ph == COAST || m_ph == CRUISE)) ? 1 : 0;
  endfunction

  // Advances the model by one clock using the inputs present at the last rising edge.
  task automatic model_step();
    bit acc, was_drive;
    int req;
    if (!rst) begin
      m_ph = COAST; m_duty = 0; m_target = 0; m_timer = 0; m_dir = 1'b0; m_pend = 1'b0;
    end else begin
      acc = cmd_bus.cmd_valid && (exp_ready() == 1);
      req = (int'(cmd_bus.cmd_duty) > MAXD) ? MAXD : int'(cmd_bus.cmd_duty);
      case (m_ph)
        COAST: begin
          if (acc) begin
            m_target = req;
            if (req != 0) begin
              m_dir = cmd_bus.cmd_dir; m_ph = DRIVE; m_timer = 0;
            end
          end
        end
        DRIVE, CRUISE: begin
          was_drive = (m_ph == DRIVE);
          if (acc) begin
            m_target = req;
            if (cmd_bus.cmd_dir != m_dir && m_duty != 0) begin
              m_pend = cmd_bus.cmd_dir; m_ph = BRAKING;
            end else begin
              m_dir = cmd_bus.cmd_dir;
              if (!was_drive && req != m_duty) m_ph = DRIVE;
            end
          end
          if (was_drive) begin
            m_timer++;
            if (m_timer == RT) begin
              m_timer = 0;
              m_duty  = move(m_duty, (m_ph == BRAKING) ? 0 : m_target);
            end
            if (m_ph == DRIVE && m_duty == m_target) m_ph = (m_target == 0) ? COAST : CRUISE;
            else if (m_ph == BRAKING && m_duty == 0) begin m_ph = DEADBAND; m_timer = 0; end
          end
        end
        BRAKING: begin
          m_timer++;
          if (m_timer == RT) begin m_timer = 0; m_duty = move(m_duty, 0); end
          if (m_duty == 0) begin m_ph = DEADBAND; m_timer = 0; end
        end
        DEADBAND: begin
          m_timer++;
          if (m_timer == DT) begin
            m_dir = m_pend; m_timer = 0; m_ph = (m_target != 0) ? DRIVE : COAST;
          end
        end
        default: m_ph = COAST;
      endcase
    end
  endtask

  task automatic cmp(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Per-cycle compare against the model, at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      model_step();
      if (cmp_en) begin
        cmp("cyc_duty", int'(duty), m_duty);
        cmp("cyc_pwm_ena", int'(pwm_ena), exp_ena());
        cmp("cyc_in1", int'(in1), exp_in1());
        cmp("cyc_in2", int'(in2), exp_in2());
        cmp("cyc_cmd_ready", int'(cmd_bus.cmd_ready), exp_ready());
        cmp("cyc_at_target", int'(at_target), exp_at_target());
        if (int'(duty) > seen_max) seen_max = int'(duty);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    cmp(name, actual, expected);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input bit valid, input bit dir, input int d);
    cmd_bus.cmd_valid = valid;
    cmd_bus.cmd_dir   = dir;
    cmd_bus.cmd_duty  = W'(d);
  endtask

  task automatic sendCmd(input bit dir, input int d);
    applyStimulus(1'b1, dir, d);
    tick();
    applyStimulus(1'b0, dir, d);
  endtask

  task automatic waitPhase(input string name, input phase_t ph, input int limit);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      tick();
      if (m_ph == ph) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("[TB] FAIL %s: phase not reached within %0d cycles", name, limit);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_duty"}, int'(duty), 0);
    checkOutput({tag, "_in1"}, int'(in1), 0);
    checkOutput({tag, "_in2"}, int'(in2), 0);
    checkOutput({tag, "_pwm_ena"}, int'(pwm_ena), 0);
    checkOutput({tag, "_cmd_ready"}, int'(cmd_bus.cmd_ready), 1);
    checkOutput({tag, "_at_target"}, int'(at_target), 1);
    checkOutput({tag, "_model_duty"}, m_duty, 0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 0);
    rst = 1'b0;
    waitCycles(3);
    rst    = 1'b1;
    cmp_en = 1'b1;
    checkResetValues("reset");

    $display("[TB] ramp-up to 35 forward");
    seen_max = 0;
    sendCmd(1'b0, 35);
    waitCycles(22);
    checkOutput("up_duty", int'(duty), 35);
    checkOutput("up_model_duty", m_duty, 35);
    checkOutput("up_at_target", int'(at_target), 1);
    checkOutput("up_in1", int'(in1), 1);
    checkOutput("up_in2", int'(in2), 0);
    checkOutput("up_max", seen_max, 35);

    $display("[TB] ramp down to 0 from 30");
    sendCmd(1'b0, 30);
    waitCycles(8);
    checkOutput("hold30_duty", int'(duty), 30);
    sendCmd(1'b0, 0);
    waitCycles(16);
    checkOutput("zero_duty", int'(duty), 0);
    checkOutput("zero_pwm_ena", int'(pwm_ena), 0);
    checkOutput("zero_in1", int'(in1), 0);
    checkOutput("zero_at_target", int'(at_target), 1);

    $display("[TB] mid-ramp override to 15");
    sendCmd(1'b0, 30);
    waitCycles(16);
    checkOutput("ovr_start", int'(duty), 30);
    sendCmd(1'b0, 0);
    waitCycles(5);
    checkOutput("ovr_mid", int'(duty), 20);
    sendCmd(1'b0, 15);
    waitCycles(10);
    checkOutput("ovr_duty", int'(duty), 15);
    checkOutput("ovr_model_duty", m_duty, 15);
    checkOutput("ovr_at_target", int'(at_target), 1);

    $display("[TB] reversal from 30 forward to 20 reverse");
    sendCmd(1'b0, 30);
    waitCycles(12);
    checkOutput("rev_start", int'(duty), 30);
    sendCmd(1'b1, 20);
    checkOutput("rev_ready_low", int'(cmd_bus.cmd_ready), 0);
    waitPhase("rev_dead_reached", DEADBAND, 40);
    checkOutput("dead_duty", int'(duty), 0);
    checkOutput("dead_pwm_ena", int'(pwm_ena), 0);
    checkOutput("dead_in1", int'(in1), BRAKE);
    checkOutput("dead_in2", int'(in2), BRAKE);
    checkOutput("dead_ready", int'(cmd_bus.cmd_ready), 0);
    waitPhase("rev_hold_reached", CRUISE, 40);
    checkOutput("rev_duty", int'(duty), 20);
    checkOutput("rev_in1", int'(in1), 0);
    checkOutput("rev_in2", int'(in2), 1);
    checkOutput("rev_ready", int'(cmd_bus.cmd_ready), 1);

    $display("[TB] clamp 400 to 320");
    seen_max = 0;
    sendCmd(1'b1, 400);
    waitCycles(130);
    checkOutput("clamp_duty", int'(duty), 320);
    checkOutput("clamp_model_duty", m_duty, 320);
    checkOutput("clamp_max", seen_max, 320);
    checkOutput("clamp_at_target", int'(at_target), 1);

    $display("[TB] reset during dead time");
    sendCmd(1'b0, 50);
    waitPhase("rst_dead_reached", DEADBAND, 200);
    waitCycles(3);
    rst = 1'b0;
    tick();
    checkResetValues("midrst");
    rst = 1'b1;
    tick();
    sendCmd(1'b0, 20);
    waitCycles(10);
    checkOutput("restart_duty", int'(duty), 20);
    checkOutput("restart_in1", int'(in1), 1);
    checkOutput("restart_in2", int'(in2), 0);
    checkOutput("restart_pwm_ena", int'(pwm_ena), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
